// File: rtl/led_axil_slave_if.sv
// AXI4-Lite bundle for the LED peripheral S00_AXI port.
// The master modport is the PS/BFM side; the slave modport is the LED responder.
interface led_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/led_axil_slave.sv
// AXI4-Lite LED peripheral: four 32-bit registers (LED_VAL, LED_CTRL,
// BLINK_PER, SCRATCH) and a registered LED bus that can blink and invert.
module led_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_W              = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    led_axil_slave_if.slave  S_AXI,
    output logic [LED_W-1:0] led
);
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic                          r_awready;
    logic                          r_bvalid;
    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_reg [4];
    logic [31:0]                   r_cnt;
    logic                          r_phase;
    logic [LED_W-1:0]              r_led;

    logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] w_araddr;
    logic [1:0]                    w_waddr;
    logic [1:0]                    w_raddr;
    logic                          w_wr_hs;
    logic                          w_rd_hs;
    logic                          w_blink_en;
    logic                          w_invert;
    logic                          w_blink_clr;
    logic                          w_unused;

    assign w_awaddr    = S_AXI.S_AXI_AWADDR;
    assign w_araddr    = S_AXI.S_AXI_ARADDR;
    assign w_waddr     = w_awaddr[3:2];
    assign w_raddr     = w_araddr[3:2];
    // AWREADY and WREADY are one shared pulse, so the write handshake is one term
    assign w_wr_hs     = r_awready & S_AXI.S_AXI_AWVALID & S_AXI.S_AXI_WVALID;
    assign w_rd_hs     = r_arready & S_AXI.S_AXI_ARVALID;
    assign w_blink_en  = r_reg[1][0];
    assign w_invert    = r_reg[1][1];
    assign w_blink_clr = w_wr_hs & ((w_waddr == 2'd1) | (w_waddr == 2'd2));
    // Byte-lane bits, aliased upper address bits and PROT are don't-cares
    assign w_unused    = ^{w_awaddr, w_araddr, S_AXI.S_AXI_AWPROT, S_AXI.S_AXI_ARPROT};

    assign S_AXI.S_AXI_AWREADY = r_awready;
    assign S_AXI.S_AXI_WREADY  = r_awready;
    assign S_AXI.S_AXI_BRESP   = 2'b00;
    assign S_AXI.S_AXI_BVALID  = r_bvalid;
    assign S_AXI.S_AXI_ARREADY = r_arready;
    assign S_AXI.S_AXI_RDATA   = r_rdata;
    assign S_AXI.S_AXI_RRESP   = 2'b00;
    assign S_AXI.S_AXI_RVALID  = r_rvalid;
    assign led                 = r_led;

    // Write address/data acceptance: one-cycle ready pulse only when both channels are valid
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awready <= 1'b0;
        end else begin
            r_awready <= ~r_awready & S_AXI.S_AXI_AWVALID & S_AXI.S_AXI_WVALID & ~r_bvalid;
        end
    end

    // Write response: raised on the handshake edge, held until BREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bvalid <= 1'b0;
        end else if (w_wr_hs) begin
            r_bvalid <= 1'b1;
        end else if (r_bvalid && S_AXI.S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register file with per-byte write strobes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
            end
        end else if (w_wr_hs) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (S_AXI.S_AXI_WSTRB[b]) begin
                    r_reg[w_waddr][8*b +: 8] <= S_AXI.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Read address acceptance: one-cycle ARREADY pulse while no read data is pending
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
        end else begin
            r_arready <= ~r_arready & S_AXI.S_AXI_ARVALID & ~r_rvalid;
        end
    end

    // Read data: captured on the ARREADY edge (sees pre-write value), held until RREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_reg[w_raddr];
        end else if (r_rvalid && S_AXI.S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    // Blink counter: counts 0..BLINK_PER and toggles phase on wrap; restarts on CTRL/PER writes
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_blink_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_blink_en && (r_reg[2] != '0)) begin
            if (r_cnt == r_reg[2]) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + 32'd1;
            end
        end
    end

    // LED drive: value gated by blink phase, then optionally inverted
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_led <= '0;
        end else begin
            r_led <= (r_reg[0][LED_W-1:0] & {LED_W{~w_blink_en | r_phase}}) ^ {LED_W{w_invert}};
        end
    end
endmodule

// File: tb/tb_led_axil_slave.sv
// Self-checking bench for led_axil_slave: scoreboarded B/R beats plus LED checks.
module tb_led_axil_slave;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] led;

    led_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    led_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .LED_W(8)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .S_AXI  (axi),
        .led    (led)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_reg [4];
    logic [31:0] q_rd [$];
    logic [1:0]  q_b  [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All driving and sampling happens 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m_reg[a[3:2]][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Present AW+W and hold until the handshake edge has passed
    task automatic wr_aw(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        axi.S_AXI_AWADDR  = a;
        axi.S_AXI_WDATA   = d;
        axi.S_AXI_WSTRB   = s;
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WVALID  = 1'b1;
        while (!axi.S_AXI_AWREADY && n < 20) begin
            tick();
            n++;
        end
        check_eq("aw_accept", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        check_eq("w_ready", {31'd0, axi.S_AXI_WREADY}, 32'd1);
        if (axi.S_AXI_AWREADY) begin
            tick();
            model_write(a, d, s);
            q_b.push_back(2'b00);
        end
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
    endtask

    task automatic wr_b();
        int n = 0;
        logic [1:0] exp;
        axi.S_AXI_BREADY = 1'b1;
        while (!axi.S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        check_eq("bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
        if (axi.S_AXI_BVALID) begin
            if (q_b.size() == 0) check_eq("b_sb_empty", 32'd1, 32'd0);
            else begin
                exp = q_b.pop_front();
                check_eq("bresp", {30'd0, axi.S_AXI_BRESP}, {30'd0, exp});
            end
            tick();
            check_eq("b_done", {31'd0, axi.S_AXI_BVALID}, 32'd0);
        end
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_aw(a, d, s);
        wr_b();
    endtask

    task automatic pop_rd(input string tag);
        logic [31:0] exp;
        if (q_rd.size() == 0) check_eq("rd_sb_empty", 32'd1, 32'd0);
        else begin
            exp = q_rd.pop_front();
            check_eq(tag, axi.S_AXI_RDATA, exp);
        end
        check_eq("rresp", {30'd0, axi.S_AXI_RRESP}, 32'd0);
    endtask

    // Read with RREADY held low for two cycles to confirm RVALID/RDATA hold
    task automatic rd(input logic [3:0] a);
        int n = 0;
        q_rd.push_back(m_reg[a[3:2]]);
        axi.S_AXI_ARADDR  = a;
        axi.S_AXI_ARVALID = 1'b1;
        while (!axi.S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        check_eq("ar_accept", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        tick();
        axi.S_AXI_ARVALID = 1'b0;
        tick();
        tick();
        check_eq("rvalid_hold", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        pop_rd("rdata");
        axi.S_AXI_RREADY = 1'b1;
        tick();
        axi.S_AXI_RREADY = 1'b0;
        check_eq("r_done", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd [4];
        logic [7:0]  exp_led;
        int n;
        wd[0] = 32'h0101FFFF; wd[1] = 32'hABCD0001; wd[2] = 32'hDEAD0011; wd[3] = 32'hBEEF0011;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
        check_eq("rst_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd0);
        check_eq("rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
        check_eq("rst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd0);
        check_eq("rst_rdata", axi.S_AXI_RDATA, 32'd0);
        check_eq("rst_led", {24'd0, led}, 32'd0);

        // Basic write/read-back of all four registers
        for (int i = 0; i < 4; i++) wr(4'(i * 4), wd[i], 4'hF);
        for (int i = 0; i < 4; i++) rd(4'(i * 4));
        // Address bits [1:0] are ignored
        rd(4'h5);
        rd(4'hB);
        // Strobe coverage: none, and middle bytes only
        wr(4'hC, 32'h12345678, 4'h0);
        rd(4'hC);
        wr(4'hC, 32'h12345678, 4'h6);
        rd(4'hC);

        // Single-byte write drives the LEDs steadily
        wr(4'h4, 32'h0, 4'hF);
        wr(4'h0, 32'h0, 4'hF);
        wr_aw(4'h0, 32'h000000A5, 4'h1);
        wr_b();
        tick();
        check_eq("led_a5", {24'd0, led}, 32'h000000A5);
        rd(4'h0);

        // B beat back-pressure blocks a second write
        axi.S_AXI_BREADY = 1'b0;
        wr_aw(4'hC, 32'hCAFE0001, 4'hF);
        axi.S_AXI_AWADDR = 4'hC; axi.S_AXI_WDATA = 32'hCAFE0002; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("bp_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
            check_eq("bp_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
        end
        wr_b();
        wr_aw(4'hC, 32'hCAFE0002, 4'hF);
        wr_b();
        rd(4'hC);

        // Blinking: period 3 -> 4 cycles per phase, then inverted
        wr(4'h8, 32'd3, 4'hF);
        wr(4'h0, 32'h000000FF, 4'hF);
        for (int inv = 0; inv < 2; inv++) begin
            wr_aw(4'h4, (inv != 0) ? 32'd3 : 32'd1, 4'hF);
            wr_b();
            for (int k = 1; k <= 16; k++) begin
                exp_led = ((((k - 1) / 4) % 2) == 0) ? 8'hFF : 8'h00;
                if (inv != 0) exp_led = ~exp_led;
                check_eq(inv != 0 ? "led_blink_inv" : "led_blink", {24'd0, led}, {24'd0, exp_led});
                if (k < 16) tick();
            end
        end
        wr(4'h4, 32'd0, 4'hF);

        // Same-edge read and write of SCRATCH returns the pre-write value
        wr(4'hC, 32'h11111111, 4'hF);
        q_rd.push_back(m_reg[3]);
        axi.S_AXI_AWADDR = 4'hC; axi.S_AXI_WDATA = 32'h22222222; axi.S_AXI_WSTRB = 4'hF;
        axi.S_AXI_ARADDR = 4'hC;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_AWREADY && n < 20) begin
            tick();
            n++;
        end
        check_eq("same_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        check_eq("same_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        tick();
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
        model_write(4'hC, 32'h22222222, 4'hF);
        q_b.push_back(2'b00);
        check_eq("same_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        pop_rd("same_rdata");
        axi.S_AXI_RREADY = 1'b1;
        tick();
        axi.S_AXI_RREADY = 1'b0;
        wr_b();
        rd(4'hC);

        // Reset while read data is pending abandons the beat and clears everything
        axi.S_AXI_ARADDR = 4'h0;
        axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!axi.S_AXI_ARREADY && n < 20) begin
            tick();
            n++;
        end
        tick();
        axi.S_AXI_ARVALID = 1'b0;
        check_eq("pre_rst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        check_eq("mid_rst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd0);
        check_eq("mid_rst_rdata", axi.S_AXI_RDATA, 32'd0);
        check_eq("mid_rst_led", {24'd0, led}, 32'd0);
        for (int i = 0; i < 4; i++) rd(4'(i * 4));
        check_eq("post_rst_led", {24'd0, led}, 32'd0);
        check_eq("sb_rd_drained", q_rd.size(), 32'd0);
        check_eq("sb_b_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
